// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the fifo write-port arbiter.
// Indices are log2 of the producer count.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  localparam int WIDTH_DEF     = 8;
  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int IDX_W         = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating priority encoder: first requester at or after start,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  logic [IW:0] p;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = {1'b0, start} + (IW+1)'(k);
      if (p >= (IW+1)'(NUM_REQ))
        p = p - (IW+1)'(NUM_REQ);
      if (!valid && req[p[IW-1:0]]) begin
        valid = 1'b1;
        idx   = p[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one fifo write port among NUM_REQ producers using
// round-robin arbitration with bounded burst ownership.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data,
  input  logic                       full,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       wr_n,
  output logic [WIDTH-1:0]           din,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] owner_inc;
  logic [IW-1:0] pick_start;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          keep;
  logic [BW-1:0] cnt_inc;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + IW'(1);
  endfunction

  assign owner_inc = inc(owner_q);
  assign keep      = (state_q == ARB_OWN) && req[owner_q];
  assign cnt_inc   = cnt_q + BW'(1);

  // A releasing owner is skipped by scanning from the next index
  assign pick_start = (state_q == ARB_OWN) ? owner_inc : rr_ptr_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_vld  = 1'b0;
    gnt_idx  = owner_q;
    if (!full) begin
      if (keep) begin
        gnt_vld = 1'b1;
        cnt_d   = cnt_inc;
        if (cnt_inc == BW'(MAX_BURST)) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = owner_inc;
        end
      end else if (pick_vld) begin
        gnt_vld = 1'b1;
        gnt_idx = pick_idx;
        owner_d = pick_idx;
        cnt_d   = BW'(1);
        if (MAX_BURST == 1) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = inc(pick_idx);
        end else begin
          state_d = ARB_OWN;
        end
      end else if (state_q == ARB_OWN) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = owner_inc;
      end
    end
  end

  always_comb begin
    gnt = '0;
    din = '0;
    if (gnt_vld && !reset) begin
      gnt[gnt_idx] = 1'b1;
      din          = data[int'(gnt_idx)*WIDTH +: WIDTH];
    end
    wr_n = ~|gnt;
  end

  assign owner = owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt));
  a_full: assert property (@(posedge clk) disable iff (reset)
    full |-> (gnt == '0));
  a_req: assert property (@(posedge clk) disable iff (reset)
    ((gnt & ~req) == '0));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: burst=4 instance plus a
// burst=1 instance for the wrap case.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [31:0] data  = '0;
  logic        full  = 1'b0;
  logic [3:0]  gnt;
  logic        wr_n;
  logic [7:0]  din;
  logic [1:0]  owner;

  logic        reset_b = 1'b1;
  logic [3:0]  req_b   = '0;
  logic [31:0] data_b  = '0;
  logic        full_b  = 1'b0;
  logic [3:0]  gnt_b;
  logic        wr_n_b;
  logic [7:0]  din_b;
  logic [1:0]  owner_b;

  fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .full(full),
    .gnt(gnt), .wr_n(wr_n), .din(din), .owner(owner)
  );

  fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .data(data_b),
    .full(full_b), .gnt(gnt_b), .wr_n(wr_n_b), .din(din_b),
    .owner(owner_b)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] din;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset = 1'b1;
    req   = r;
    full  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 4'b1111;
    data  = 32'h44332211;
    tick();
    #1;
    checks++;
    if (gnt !== 4'b0000 || wr_n !== 1'b1 || din !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: gnt=%b wr_n=%b din=%h want 0000 1 00",
               gnt, wr_n, din);
    end
    checks++;
    if (owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_owner: got %0d want 0", owner);
    end
    tick();
    reset = 1'b0;
    q.push_back('{4'b0001, 8'h11});
    #1;
    e = q.pop_front();
    checks++;
    if (gnt !== e.gnt || din !== e.din || wr_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_first: gnt=%b din=%h want %b %h",
               gnt, din, e.gnt, e.din);
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] w [4];
    int idx;
    for (int i = 0; i < 4; i++) w[i] = 8'(8'h30 + i);
    data = {w[3], w[2], w[1], w[0]};
    do_reset(4'b1111);
    for (int n = 0; n < 20; n++) begin
      idx = (n / 4) % 4;
      q.push_back('{4'(1 << idx), w[idx]});
      #1;
      e = q.pop_front();
      checks++;
      if (wr_n !== 1'b0 || gnt !== e.gnt || din !== e.din) begin
        errors++;
        $display("FAIL rr_cycle%0d: gnt=%b din=%h wr_n=%b want %b %h 0",
                 n, gnt, din, wr_n, e.gnt, e.din);
      end
      tick();
      w[idx] = 8'($urandom);
      data[idx*8 +: 8] = w[idx];
    end
  endtask

  task automatic test_release;
    data = 32'h00C300A5;
    do_reset(4'b0000);
    req = 4'b0101;
    q.push_back('{4'b0001, 8'hA5});
    q.push_back('{4'b0001, 8'h5A});
    q.push_back('{4'b0100, 8'hC3});
    for (int n = 0; n < 3; n++) begin
      #1;
      e = q.pop_front();
      checks++;
      if (wr_n !== 1'b0 || gnt !== e.gnt || din !== e.din) begin
        errors++;
        $display("FAIL release_%0d: gnt=%b din=%h wr_n=%b want %b %h 0",
                 n, gnt, din, wr_n, e.gnt, e.din);
      end
      tick();
      if (n == 0) data[7:0] = 8'h5A;
      if (n == 1) req[0] = 1'b0;
      if (n == 2) req[2] = 1'b0;
    end
    #1;
    checks++;
    if (gnt !== 4'b0000 || wr_n !== 1'b1) begin
      errors++;
      $display("FAIL release_idle: gnt=%b wr_n=%b want 0000 1", gnt, wr_n);
    end
  endtask

  task automatic test_full;
    data = 32'h00201000;
    do_reset(4'b0000);
    req = 4'b0110;
    q.push_back('{4'b0010, 8'h10});
    q.push_back('{4'b0010, 8'h11});
    for (int n = 0; n < 2; n++) begin
      #1;
      e = q.pop_front();
      checks++;
      if (gnt !== e.gnt || din !== e.din) begin
        errors++;
        $display("FAIL full_pre%0d: gnt=%b din=%h want %b %h",
                 n, gnt, din, e.gnt, e.din);
      end
      tick();
      data[15:8] = 8'(data[15:8] + 8'd1);
    end
    full = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (gnt !== 4'b0000 || wr_n !== 1'b1 || owner !== 2'd1) begin
        errors++;
        $display("FAIL full_stall%0d: gnt=%b wr_n=%b owner=%0d want 0000 1 1",
                 n, gnt, wr_n, owner);
      end
      tick();
    end
    full = 1'b0;
    q.push_back('{4'b0010, 8'h12});
    q.push_back('{4'b0010, 8'h13});
    q.push_back('{4'b0100, 8'h20});
    for (int n = 0; n < 3; n++) begin
      #1;
      e = q.pop_front();
      checks++;
      if (wr_n !== 1'b0 || gnt !== e.gnt || din !== e.din) begin
        errors++;
        $display("FAIL full_post%0d: gnt=%b din=%h want %b %h",
                 n, gnt, din, e.gnt, e.din);
      end
      tick();
      if (n < 2) data[15:8] = 8'(data[15:8] + 8'd1);
    end
    req = 4'b0000;
  endtask

  task automatic test_burst1_wrap;
    data_b  = 32'hB30000B0;
    reset_b = 1'b1;
    req_b   = 4'b1001;
    tick();
    reset_b = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 0) q.push_back('{4'b0001, 8'hB0});
      else            q.push_back('{4'b1000, 8'hB3});
      #1;
      e = q.pop_front();
      checks++;
      if (wr_n_b !== 1'b0 || gnt_b !== e.gnt || din_b !== e.din) begin
        errors++;
        $display("FAIL wrap_%0d: gnt=%b din=%h want %b %h",
                 n, gnt_b, din_b, e.gnt, e.din);
      end
      tick();
    end
    req_b = 4'b0000;
  endtask

  task automatic test_reset_mid;
    data = 32'hD3D2D1D0;
    do_reset(4'b0100);
    q.push_back('{4'b0100, 8'hD2});
    q.push_back('{4'b0100, 8'hD2});
    for (int n = 0; n < 2; n++) begin
      #1;
      e = q.pop_front();
      checks++;
      if (gnt !== e.gnt || din !== e.din) begin
        errors++;
        $display("FAIL mid_pre%0d: gnt=%b din=%h want %b %h",
                 n, gnt, din, e.gnt, e.din);
      end
      tick();
      req = 4'b1111;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || wr_n !== 1'b1 || din !== 8'h00) begin
      errors++;
      $display("FAIL mid_async: gnt=%b wr_n=%b din=%h want 0000 1 00",
               gnt, wr_n, din);
    end
    tick();
    reset = 1'b0;
    q.push_back('{4'b0001, 8'hD0});
    #1;
    e = q.pop_front();
    checks++;
    if (wr_n !== 1'b0 || gnt !== e.gnt || din !== e.din) begin
      errors++;
      $display("FAIL mid_restart: gnt=%b din=%h want %b %h",
               gnt, din, e.gnt, e.din);
    end
    tick();
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_release();
    test_full();
    test_burst1_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
